pwm_multichannel: RTL

//  Parametrised N-channel PWM generator for the onboarding user project.

---
 rtl/pwm_multichannel.sv | 107 ++++++++++
 1 files changed

// File: rtl/pwm_multichannel.sv
// N-channel PWM generator with a clock prescaler and double-buffered duty/mode
// registers. New settings take effect only at a period boundary.
module pwm_multichannel #(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned PRE_W  = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          out_en_i,
    input  logic [NUM_CH-1:0]          pwm_en_i,
    input  logic [NUM_CH*DUTY_W-1:0]   duty_flat_i,
    input  logic [PRE_W-1:0]           prescale_i,
    input  logic                       load_i,
    output logic [NUM_CH-1:0]          pwm_out_o,
    output logic                       period_start_o,
    output logic                       load_pending_o
);

    // Last counter value; a full duty of all-ones is never reached and stays high.
    localparam logic [DUTY_W-1:0] MaxC = {{(DUTY_W-1){1'b1}}, 1'b0};

    logic [PRE_W-1:0]         pre_cnt_q, pre_cnt_d;
    logic [DUTY_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH*DUTY_W-1:0] shd_duty_q, shd_duty_d;
    logic [NUM_CH-1:0]        shd_pwm_en_q, shd_pwm_en_d;
    logic [NUM_CH*DUTY_W-1:0] act_duty_q, act_duty_d;
    logic [NUM_CH-1:0]        act_pwm_en_q, act_pwm_en_d;
    logic [NUM_CH-1:0]        pwm_out_q, pwm_out_d;
    logic                     period_start_q, period_start_d;
    logic                     load_pending_q, load_pending_d;
    logic                     tick;
    logic                     wrap;

    // ">=" lets a lowered prescale take effect without waiting for a full wrap.
    assign tick = (pre_cnt_q >= prescale_i);
    assign wrap = tick && (cnt_q == MaxC);

    always_comb begin
        pre_cnt_d      = tick ? '0 : pre_cnt_q + PRE_W'(1);
        cnt_d          = cnt_q;
        shd_duty_d     = shd_duty_q;
        shd_pwm_en_d   = shd_pwm_en_q;
        act_duty_d     = act_duty_q;
        act_pwm_en_d   = act_pwm_en_q;
        load_pending_d = load_pending_q;
        period_start_d = wrap;
        pwm_out_d      = '0;

        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + DUTY_W'(1);
        end

        if (load_i) begin
            shd_duty_d     = duty_flat_i;
            shd_pwm_en_d   = pwm_en_i;
            load_pending_d = 1'b1;
        end

        if (wrap) begin
            if (load_i) begin
                // Coincident load bypasses the shadow and never shows as pending.
                act_duty_d     = duty_flat_i;
                act_pwm_en_d   = pwm_en_i;
                load_pending_d = 1'b0;
            end else if (load_pending_q) begin
                act_duty_d     = shd_duty_q;
                act_pwm_en_d   = shd_pwm_en_q;
                load_pending_d = 1'b0;
            end
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_out_d[i] = out_en_i[i] &
                (act_pwm_en_q[i] ? (cnt_q < act_duty_q[i*DUTY_W +: DUTY_W]) : 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            cnt_q          <= '0;
            shd_duty_q     <= '0;
            shd_pwm_en_q   <= '0;
            act_duty_q     <= '0;
            act_pwm_en_q   <= '0;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
            load_pending_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            cnt_q          <= cnt_d;
            shd_duty_q     <= shd_duty_d;
            shd_pwm_en_q   <= shd_pwm_en_d;
            act_duty_q     <= act_duty_d;
            act_pwm_en_q   <= act_pwm_en_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            load_pending_q <= load_pending_d;
        end
    end

    assign pwm_out_o      = pwm_out_q;
    assign period_start_o = period_start_q;
    assign load_pending_o = load_pending_q;

endmodule
